// File: rtl/traffic_ctrl_n_if.sv
// Handshake bundle for traffic_ctrl_n: timing/request inputs and light outputs.
// master drives tick/night/ped_req; slave (the controller) drives the rest.
//   tick     : one-cycle timing enable
//   night    : night-mode request level
//   ped_req  : pedestrian button
//   lights   : {red,yellow,green} per direction, 3*NUM_DIR bits
//   active   : direction owning green/yellow
//   phase    : GREEN=0 YELLOW=1 ALLRED=2 NIGHT_ON=3 NIGHT_OFF=4
//   ped_wait : pending pedestrian request
interface traffic_ctrl_n_if #(
    parameter int NUM_DIR = 2
);
    localparam int AW = $clog2(NUM_DIR);

    logic                   tick;
    logic                   night;
    logic                   ped_req;
    logic [3*NUM_DIR-1:0]   lights;
    logic [AW-1:0]          active;
    logic [2:0]             phase;
    logic                   ped_wait;

    modport master (
        output tick,
        output night,
        output ped_req,
        input  lights,
        input  active,
        input  phase,
        input  ped_wait
    );

    modport slave (
        input  tick,
        input  night,
        input  ped_req,
        output lights,
        output active,
        output phase,
        output ped_wait
    );
endinterface

// File: rtl/traffic_ctrl_n.sv
// N-direction round-robin traffic-light controller with tick-based phase
// timer, pedestrian early green termination and flashing-yellow night mode.
// Ports: clk, clr (sync active-high reset), bus (traffic_ctrl_n_if.slave).
module traffic_ctrl_n #(
    parameter int NUM_DIR      = 2,
    parameter int GREEN_TICKS  = 45,
    parameter int GREEN_MIN    = 15,
    parameter int YELLOW_TICKS = 5,
    parameter int ALLRED_TICKS = 1
) (
    input  logic              clk,
    input  logic              clr,
    traffic_ctrl_n_if.slave   bus
);
    localparam int AW   = $clog2(NUM_DIR);
    localparam int MAXA = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAXT = (MAXA > ALLRED_TICKS) ? MAXA : ALLRED_TICKS;
    localparam int CW   = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        GREEN     = 3'd0,
        YELLOW    = 3'd1,
        ALLRED    = 3'd2,
        NIGHT_ON  = 3'd3,
        NIGHT_OFF = 3'd4
    } phase_t;

    phase_t                 phase_q;
    logic [AW-1:0]          active_q;
    logic [CW-1:0]          cnt;
    logic                   ped_pend;
    logic [3*NUM_DIR-1:0]   lights_w;

    logic g_done;
    logic g_cut;
    logic leave_g;
    logic in_night;

    assign g_done   = (cnt == CW'(GREEN_TICKS - 1));
    // A pending request may only cut green once the minimum has elapsed.
    assign g_cut    = ped_pend && (cnt >= CW'(GREEN_MIN - 1));
    assign leave_g  = bus.tick && (phase_q == GREEN) && (g_done || g_cut);
    assign in_night = (phase_q == NIGHT_ON) || (phase_q == NIGHT_OFF);

    always_ff @(posedge clk) begin
        if (clr) begin
            phase_q  <= GREEN;
            active_q <= '0;
            cnt      <= '0;
            ped_pend <= 1'b0;
        end else begin
            // Request set wins over the clear on the green->yellow cycle.
            if (in_night) begin
                ped_pend <= 1'b0;
            end else if (bus.ped_req) begin
                ped_pend <= 1'b1;
            end else if (leave_g) begin
                ped_pend <= 1'b0;
            end

            if (bus.tick) begin
                unique case (phase_q)
                    GREEN: begin
                        if (g_done || g_cut) begin
                            phase_q <= YELLOW;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    YELLOW: begin
                        if (cnt == CW'(YELLOW_TICKS - 1)) begin
                            phase_q <= ALLRED;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ALLRED: begin
                        if (cnt == CW'(ALLRED_TICKS - 1)) begin
                            cnt <= '0;
                            if (bus.night) begin
                                phase_q <= NIGHT_ON;
                            end else begin
                                phase_q  <= GREEN;
                                active_q <= (active_q == AW'(NUM_DIR - 1))
                                          ? '0 : active_q + AW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    NIGHT_ON: begin
                        cnt     <= '0;
                        phase_q <= bus.night ? NIGHT_OFF : ALLRED;
                    end
                    NIGHT_OFF: begin
                        cnt     <= '0;
                        phase_q <= bus.night ? NIGHT_ON : ALLRED;
                    end
                    default: begin
                        phase_q  <= GREEN;
                        active_q <= '0;
                        cnt      <= '0;
                    end
                endcase
            end
        end
    end

    // Moore decode; red is the default for every non-owning direction.
    always_comb begin
        lights_w = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            unique case (phase_q)
                GREEN:
                    lights_w[3*i +: 3] = (active_q == AW'(i)) ? 3'b001 : 3'b100;
                YELLOW:
                    lights_w[3*i +: 3] = (active_q == AW'(i)) ? 3'b010 : 3'b100;
                ALLRED:
                    lights_w[3*i +: 3] = 3'b100;
                NIGHT_ON:
                    lights_w[3*i +: 3] = 3'b010;
                NIGHT_OFF:
                    lights_w[3*i +: 3] = 3'b000;
                default:
                    lights_w[3*i +: 3] = 3'b100;
            endcase
        end
    end

    assign bus.lights   = lights_w;
    assign bus.active   = active_q;
    assign bus.phase    = phase_q;
    assign bus.ped_wait = ped_pend;

endmodule

// File: doc/traffic_ctrl_n.md
# traffic_ctrl_n

Parametrised N-direction traffic-light controller with an integrated phase timer, a pedestrian early-termination request and a flashing-yellow night mode. It sits behind the clock divider and consumes a one-cycle `tick` enable (nominally 1 Hz). It replaces the fixed two-direction controller driven by separate 15 s/45 s pulses. All timing is counted internally in ticks.

## Interface
- `NUM_DIR`, 2: number of directions served round-robin; legal range 2..4.
- `GREEN_TICKS`, 45: maximum green duration in ticks; must be at least 1.
- `GREEN_MIN`, 15: minimum green before a pedestrian request may end it; legal range 1..GREEN_TICKS.
- `YELLOW_TICKS`, 5: yellow duration in ticks; must be at least 1.
- `ALLRED_TICKS`, 1: all-red clearance in ticks; must be at least 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `clr`  in  1  reset; synchronous, active-high.
- `tick`  in  1  one-cycle timing enable; all counting and phase changes occur only on cycles where tick=1.
- `night`  in  1  level; night-mode request.
- `ped_req`  in  1  pedestrian button; any-cycle pulse or level.
- `lights`  out  3*NUM_DIR  lights[3i+2:3i] = {red, yellow, green} for direction i.
- `active`  out  $clog2(NUM_DIR)  index of the direction currently owning green/yellow.
- `phase`  out  3  GREEN=0, YELLOW=1, ALLRED=2, NIGHT_ON=3, NIGHT_OFF=4.
- `ped_wait`  out  1  pending pedestrian request flag.

## Operation
- Registered state: `phase`, `active`, tick counter `cnt` (width sized for GREEN_TICKS), and `ped_pend`.
- `lights` is a combinational Moore decode of `phase` and `active`. Each output is valid in the same cycle as its state.
- GREEN: direction `active` = 001, all other directions = 100. On each tick, `cnt`++.
  - Leave GREEN on a tick where cnt==GREEN_TICKS-1.
  - Also leave GREEN on a tick where ped_pend=1 and cnt>=GREEN_MIN-1.
  - On leaving: go to YELLOW, cnt=0.
- YELLOW: direction `active` = 010, all others = 100. On the tick where cnt==YELLOW_TICKS-1, go to ALLRED with cnt=0.
- ALLRED: all directions = 100. On the tick where cnt==ALLRED_TICKS-1:
  - if night=1, go to NIGHT_ON with cnt=0;
  - otherwise go to GREEN with cnt=0 and active = (active==NUM_DIR-1) ? 0 : active+1.
- NIGHT_ON: all directions = 010. NIGHT_OFF: all directions = 000.
  - Each tick toggles between NIGHT_ON and NIGHT_OFF while night=1.
  - A tick with night=0 goes to ALLRED with cnt=0 and `active` unchanged. The next green therefore goes to active+1.
- Night entry occurs only from ALLRED completion. night=1 during GREEN or YELLOW lets the normal cycle finish first.
- `ped_pend` behaviour:
  - Set on any cycle with ped_req=1 while phase is GREEN, YELLOW or ALLRED.
  - Cleared on the cycle GREEN→YELLOW is taken. If ped_req=1 in that same cycle, set wins and the request is retained.
  - Forced to 0 in NIGHT_ON/NIGHT_OFF; ped_req is ignored there.
  - A request raised during YELLOW or ALLRED applies to the next green.
- `ped_wait` = `ped_pend`.
- Cycles with tick=0 change nothing except `ped_pend`.

## Timing
- Reset (clr=1 at a clk edge, regardless of tick or current phase, including mid-phase or mid-night) gives on the next cycle:
  - phase=GREEN, active=0, cnt=0, ped_pend=0;
  - lights = direction 0 = 001, others = 100. For NUM_DIR=2, lights=6'b100_001.
- Latency from the deciding tick to the new phase/lights is 1 clk cycle (registered transition).
- Phase durations in ticks:
  - green = GREEN_TICKS, or fewer when cut by a pedestrian request but never fewer than GREEN_MIN;
  - yellow = YELLOW_TICKS;
  - all-red = ALLRED_TICKS.
- A ped_req coincident with a tick is not seen by that tick's decision, because ped_pend is not yet set. The earliest early exit is the following tick.
- `active` wraps from NUM_DIR-1 to 0. No two directions are ever non-red in the same cycle.
- tick held high continuously is legal: every cycle is then one tick.

## Test plan
- Defaults, tick every cycle, clr for 2 cycles, then run 102 cycles:
  - GREEN for 45 cycles with lights=100_001;
  - YELLOW for 5 with 100_010;
  - ALLRED for 1 with 100_100;
  - GREEN with active=1 and 001_100;
  - after 51 more cycles, active wraps back to 0.
- ped_req pulse at GREEN cnt=3: ped_wait=1 next cycle; YELLOW entered after exactly 15 ticks of green; ped_wait=0 after the transition.
- ped_req pulse at GREEN cnt=30 coincident with a tick: YELLOW entered on the tick after next (green lasts 32 ticks).
- night=1 raised at GREEN cnt=10: yellow and all-red run normally, then lights alternate 010_010 / 000_000 every tick. ped_req is ignored (ped_wait stays 0). Dropping night gives ALLRED for 1 tick, then GREEN with the next direction.
- NUM_DIR=4, GREEN_TICKS=3, GREEN_MIN=1, YELLOW_TICKS=2, ALLRED_TICKS=1, tick every 4th cycle: active sequence 0,1,2,3,0. Each green lasts 12 clk cycles. Exactly one direction is non-red at any time.
- clr asserted mid-YELLOW with tick=0: on the next cycle phase=GREEN, active=0, cnt=0, ped_wait=0, lights=100_001.
